// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execution core:
//   - 4-bit operation codes (F_AND .. F_SRL)
//   - FSM state constants (ST_IDLE, ST_ITER)
//   - iterative unit mode enum (MD_MUL, MD_DIV, MD_MOD)
//   - is_muldiv(): true for the operations that run on the iterative unit
// -----------------------------------------------------------------------------
package exec_pkg;

   localparam logic [3:0] F_AND  = 4'd0;
   localparam logic [3:0] F_OR   = 4'd1;
   localparam logic [3:0] F_XOR  = 4'd2;
   localparam logic [3:0] F_NOT  = 4'd3;
   localparam logic [3:0] F_ADD  = 4'd4;
   localparam logic [3:0] F_SUB  = 4'd5;
   localparam logic [3:0] F_PASS = 4'd6;
   localparam logic [3:0] F_MOVB = 4'd7;
   localparam logic [3:0] F_MUL  = 4'd8;
   localparam logic [3:0] F_DIV  = 4'd9;
   localparam logic [3:0] F_MOD  = 4'd10;
   localparam logic [3:0] F_EQ   = 4'd11;
   localparam logic [3:0] F_LTU  = 4'd12;
   localparam logic [3:0] F_GEU  = 4'd13;
   localparam logic [3:0] F_SLL  = 4'd14;
   localparam logic [3:0] F_SRL  = 4'd15;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ITER = 1'b1;

   typedef enum logic [1:0] {
      MD_MUL = 2'd0,
      MD_DIV = 2'd1,
      MD_MOD = 2'd2
   } md_mode_e;

   function automatic logic is_muldiv(input logic [3:0] f);
      return (f == F_MUL) || (f == F_DIV) || (f == F_MOD);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle. A start pulse latches the operands; exactly DATA_W steps follow.
// done is high during the last step and result then carries the value that
// step produces, so the caller can register it on the same edge.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             latch a/b/mode and begin iterating
//   mode              MD_MUL / MD_DIV / MD_MOD
//   a, b              operands (a*b, a/b, a%b)
//   busy              iteration in progress
//   done              final step in progress (result valid)
//   result            2*DATA_W result (DIV/MOD zero-extended)
// -----------------------------------------------------------------------------
module seq_muldiv
   import exec_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic                busy,
   output logic                done,
   output logic [2*DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DATA_W);

   logic                busy_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [1:0]          mode_r;
   logic [DATA_W-1:0]   opd_r;     // multiplicand (MUL) or divisor (DIV/MOD)
   logic [DATA_W-1:0]   hi_r;      // product high half or partial remainder
   logic [DATA_W-1:0]   lo_r;      // multiplier bits or dividend/quotient bits
   logic [DATA_W:0]     sum_s;
   logic [DATA_W:0]     shift_s;
   logic [DATA_W+1:0]   diff_s;
   logic [DATA_W-1:0]   nxt_hi_s;
   logic [DATA_W-1:0]   nxt_lo_s;

   assign busy = busy_r;
   assign done = busy_r && (cnt_r == CNT_W'(DATA_W-1));

   // One iteration step: shift-add for MUL, trial subtract for DIV/MOD.
   always_comb begin
      sum_s    = '0;
      shift_s  = '0;
      diff_s   = '0;
      nxt_hi_s = hi_r;
      nxt_lo_s = lo_r;
      if (mode_r == MD_MUL) begin
         sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(DATA_W+1){1'b0}});
         {nxt_hi_s, nxt_lo_s} = {sum_s, lo_r[DATA_W-1:1]};
      end else begin
         // Divisor of zero never borrows: quotient fills with ones and the
         // remainder ends up holding the whole dividend.
         shift_s = {hi_r, lo_r[DATA_W-1]};
         diff_s  = {1'b0, shift_s} - {2'b00, opd_r};
         if (diff_s[DATA_W+1]) begin
            nxt_hi_s = shift_s[DATA_W-1:0];
            nxt_lo_s = {lo_r[DATA_W-2:0], 1'b0};
         end else begin
            nxt_hi_s = diff_s[DATA_W-1:0];
            nxt_lo_s = {lo_r[DATA_W-2:0], 1'b1};
         end
      end
   end

   // Select the result view for the active mode.
   always_comb begin
      if (mode_r == MD_MUL) begin
         result = {nxt_hi_s, nxt_lo_s};
      end else if (mode_r == MD_DIV) begin
         result = {{DATA_W{1'b0}}, nxt_lo_s};
      end else begin
         result = {{DATA_W{1'b0}}, nxt_hi_s};
      end
   end

   // Operand capture, step counter and shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         cnt_r  <= '0;
         mode_r <= MD_MUL;
         opd_r  <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else if (start) begin
         busy_r <= 1'b1;
         cnt_r  <= '0;
         mode_r <= mode;
         hi_r   <= '0;
         if (mode == MD_MUL) begin
            opd_r <= a;
            lo_r  <= b;
         end else begin
            opd_r <= b;
            lo_r  <= a;
         end
      end else if (busy_r) begin
         hi_r <= nxt_hi_s;
         lo_r <= nxt_lo_s;
         if (done) begin
            busy_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/exec_core_p.sv
// -----------------------------------------------------------------------------
// exec_core_p
// Parametrised execution core: register file, single-cycle ALU, iterative
// MUL/DIV/MOD unit, registered result and flags, valid/ready instruction
// handshake.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   func, rd, rs1, rs2       operation and register addresses
//   imm_sel, imm             operand2 = imm when imm_sel, else reg[rs2]
//   wr_en                    write result back to rd
//   res_valid, res_data      one-cycle result pulse, 2*DATA_W result
//   flag_zero, flag_carry    registered flags of the last result
//   dbg_addr, dbg_data       combinational register read port
// -----------------------------------------------------------------------------
module exec_core_p
   import exec_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int NREG   = 8,
   localparam int REG_AW = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [3:0]          func,
   input  logic [REG_AW-1:0]   rd,
   input  logic [REG_AW-1:0]   rs1,
   input  logic [REG_AW-1:0]   rs2,
   input  logic                imm_sel,
   input  logic [DATA_W-1:0]   imm,
   input  logic                wr_en,
   output logic                res_valid,
   output logic [2*DATA_W-1:0] res_data,
   output logic                flag_zero,
   output logic                flag_carry,
   input  logic [REG_AW-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

   logic [DATA_W-1:0]   reg_r [NREG];
   logic [0:0]          state_r;
   logic                res_valid_r;
   logic [2*DATA_W-1:0] res_data_r;
   logic                flag_zero_r;
   logic                flag_carry_r;
   logic [REG_AW-1:0]   rd_hold_r;
   logic                wr_hold_r;
   logic                mul_hold_r;

   logic                accept_s;
   logic [DATA_W-1:0]   op1_s;
   logic [DATA_W-1:0]   op2_s;
   logic [DATA_W:0]     add_s;
   logic [DATA_W:0]     sub_s;
   logic [DATA_W-1:0]   alu_s;
   logic                carry_s;
   logic [1:0]          md_mode_s;
   logic                md_busy_s;
   logic                md_done_s;
   logic [2*DATA_W-1:0] md_result_s;

   assign instr_ready = (state_r == ST_IDLE);
   assign accept_s    = instr_valid && (state_r == ST_IDLE);
   assign op1_s       = reg_r[rs1];
   assign op2_s       = imm_sel ? imm : reg_r[rs2];
   assign res_valid   = res_valid_r;
   assign res_data    = res_data_r;
   assign flag_zero   = flag_zero_r;
   assign flag_carry  = flag_carry_r;
   assign dbg_data    = reg_r[dbg_addr];

   // Single-cycle ALU; carry/borrow only for ADD/SUB.
   always_comb begin
      add_s   = {1'b0, op1_s} + {1'b0, op2_s};
      sub_s   = {1'b0, op1_s} - {1'b0, op2_s};
      alu_s   = '0;
      carry_s = 1'b0;
      case (func)
         F_AND:  alu_s = op1_s & op2_s;
         F_OR:   alu_s = op1_s | op2_s;
         F_XOR:  alu_s = op1_s ^ op2_s;
         F_NOT:  alu_s = ~op1_s;
         F_ADD:  begin alu_s = add_s[DATA_W-1:0]; carry_s = add_s[DATA_W]; end
         F_SUB:  begin alu_s = sub_s[DATA_W-1:0]; carry_s = sub_s[DATA_W]; end
         F_PASS: alu_s = op1_s;
         F_MOVB: alu_s = op2_s;
         F_EQ:   alu_s = {{(DATA_W-1){1'b0}}, (op1_s == op2_s)};
         F_LTU:  alu_s = {{(DATA_W-1){1'b0}}, (op1_s <  op2_s)};
         F_GEU:  alu_s = {{(DATA_W-1){1'b0}}, (op1_s >= op2_s)};
         F_SLL:  alu_s = (op2_s < SH_LIM) ? (op1_s << op2_s) : {DATA_W{1'b0}};
         F_SRL:  alu_s = (op2_s < SH_LIM) ? (op1_s >> op2_s) : {DATA_W{1'b0}};
         default: alu_s = '0;
      endcase
   end

   // Map the operation code onto the iterative unit's mode.
   always_comb begin
      case (func)
         F_MUL:   md_mode_s = MD_MUL;
         F_DIV:   md_mode_s = MD_DIV;
         default: md_mode_s = MD_MOD;
      endcase
   end

   seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept_s && is_muldiv(func)),
      .mode   (md_mode_s),
      .a      (op1_s),
      .b      (op2_s),
      .busy   (md_busy_s),
      .done   (md_done_s),
      .result (md_result_s)
   );

   // FSM, result/flag registers and register-file writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         res_valid_r  <= 1'b0;
         res_data_r   <= '0;
         flag_zero_r  <= 1'b1;
         flag_carry_r <= 1'b0;
         rd_hold_r    <= '0;
         wr_hold_r    <= 1'b0;
         mul_hold_r   <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            reg_r[i] <= DATA_W'(i);
         end
      end else begin
         res_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (is_muldiv(func)) begin
                     state_r    <= ST_ITER;
                     rd_hold_r  <= rd;
                     wr_hold_r  <= wr_en;
                     mul_hold_r <= (func == F_MUL);
                  end else begin
                     res_valid_r  <= 1'b1;
                     res_data_r   <= {{DATA_W{1'b0}}, alu_s};
                     flag_zero_r  <= (alu_s == '0);
                     flag_carry_r <= carry_s;
                     if (wr_en) begin
                        reg_r[rd] <= alu_s;
                     end
                  end
               end
            end
            ST_ITER: begin
               if (md_done_s) begin
                  state_r      <= ST_IDLE;
                  res_valid_r  <= 1'b1;
                  res_data_r   <= md_result_s;
                  flag_zero_r  <= (md_result_s == '0);
                  flag_carry_r <= 1'b0;
                  if (wr_hold_r) begin
                     reg_r[rd_hold_r] <= md_result_s[DATA_W-1:0];
                     // High half lands in rd+1, wrapping past the last register.
                     if (mul_hold_r) begin
                        reg_r[rd_hold_r + REG_AW'(1)] <= md_result_s[2*DATA_W-1:DATA_W];
                     end
                  end
               end else if (!md_busy_s) begin
                  // Unit idle while we think it runs: recover without a result.
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_core_p.sv
module tb_exec_core_p;
   import exec_pkg::*;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam longint unsigned MASK = (64'd1 << DW) - 64'd1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic          instr_ready;
   logic [3:0]    func;
   logic [AW-1:0] rd, rs1, rs2;
   logic          imm_sel;
   logic [DW-1:0] imm;
   logic          wr_en;
   logic          res_valid;
   logic [2*DW-1:0] res_data;
   logic          flag_zero, flag_carry;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   always #5 clk = ~clk;

   exec_core_p #(.DATA_W(DW), .NREG(NR)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .func(func), .rd(rd), .rs1(rs1), .rs2(rs2), .imm_sel(imm_sel), .imm(imm),
      .wr_en(wr_en), .res_valid(res_valid), .res_data(res_data),
      .flag_zero(flag_zero), .flag_carry(flag_carry),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   int checks = 0;
   int failures = 0;
   longint unsigned mreg [NR];

   typedef struct {
      logic [3:0]      f;
      int              rd, rs1, rs2;
      bit              isel;
      longint unsigned imm;
      bit              we;
      longint unsigned exp_data;
      bit              exp_c;
      int              exp_lat;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference behaviour from plain arithmetic.
   function automatic void model_calc(input logic [3:0] f, input longint unsigned a,
                                      input longint unsigned b, output longint unsigned res,
                                      output bit c, output int lat);
      c = 1'b0;
      lat = 1;
      case (f)
         F_AND:  res = a & b;
         F_OR:   res = a | b;
         F_XOR:  res = a ^ b;
         F_NOT:  res = ~a & MASK;
         F_ADD:  begin res = (a + b) & MASK; c = (a + b) > MASK; end
         F_SUB:  begin res = (a - b) & MASK; c = a < b; end
         F_PASS: res = a;
         F_MOVB: res = b;
         F_MUL:  begin res = a * b; lat = DW + 1; end
         F_DIV:  begin res = (b == 0) ? MASK : a / b; lat = DW + 1; end
         F_MOD:  begin res = (b == 0) ? a : a % b; lat = DW + 1; end
         F_EQ:   res = (a == b) ? 1 : 0;
         F_LTU:  res = (a < b) ? 1 : 0;
         F_GEU:  res = (a >= b) ? 1 : 0;
         F_SLL:  res = (b >= DW) ? 0 : (a << b) & MASK;
         default: res = (b >= DW) ? 0 : (a >> b);
      endcase
   endfunction

   function automatic void model_commit(input logic [3:0] f, input int rdi,
                                        input longint unsigned res, input bit we);
      if (we) begin
         mreg[rdi] = res & MASK;
         if (f == F_MUL) mreg[(rdi + 1) % NR] = (res >> DW) & MASK;
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) mreg[i] = longint'(i) & MASK;
   endfunction

   task automatic sweep(input string tag);
      for (int i = 0; i < NR; i++) begin
         dbg_addr = AW'(i);
         #1;
         chk($sformatf("%s_reg%0d", tag, i), 64'(dbg_data), mreg[i]);
      end
   endtask

   // Offer one instruction, wait for its result, check result, flags, latency.
   task automatic exec_check(input string tag, input logic [3:0] f, input int rdi,
                             input int rs1i, input int rs2i, input bit isel,
                             input longint unsigned immv, input bit we,
                             input longint unsigned exp_data, input bit exp_c, input int exp_lat);
      int guard;
      int lat;
      int ready_bad;
      @(negedge clk);
      func = f; rd = AW'(rdi); rs1 = AW'(rs1i); rs2 = AW'(rs2i);
      imm_sel = isel; imm = DW'(immv); wr_en = we; instr_valid = 1'b1;
      guard = 0;
      while (!instr_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      lat = 0;
      ready_bad = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!res_valid && instr_ready) ready_bad++;
      end while (!res_valid && lat < 40);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_data"}, 64'(res_data), exp_data);
      chk({tag, "_zero"}, 64'(flag_zero), (exp_data == 0) ? 64'd1 : 64'd0);
      chk({tag, "_carry"}, 64'(flag_carry), 64'(exp_c));
      chk({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(res_valid), 64'd0);
   endtask

   initial begin
      longint unsigned res, a, b;
      bit c;
      int lat, k, pulses, first_k, second_k, ready_bad;
      longint unsigned first_d, second_d;

      tbl[0]  = '{F_ADD,  1, 2, 3, 1'b0, 0,   1'b1, 16'h0005, 1'b0, 1};
      tbl[1]  = '{F_ADD,  6, 1, 0, 1'b1, 251, 1'b1, 16'h0000, 1'b1, 1};
      tbl[2]  = '{F_SUB,  4, 6, 0, 1'b1, 1,   1'b1, 16'h00FF, 1'b1, 1};
      tbl[3]  = '{F_ADD,  7, 0, 0, 1'b1, 200, 1'b1, 16'h00C8, 1'b0, 1};
      tbl[4]  = '{F_MUL,  7, 7, 0, 1'b1, 3,   1'b1, 16'h0258, 1'b0, 9};
      tbl[5]  = '{F_DIV,  2, 5, 0, 1'b1, 0,   1'b1, 16'h00FF, 1'b0, 9};
      tbl[6]  = '{F_MOD,  3, 5, 0, 1'b1, 0,   1'b0, 16'h0005, 1'b0, 9};
      tbl[7]  = '{F_SLL,  0, 5, 0, 1'b1, 8,   1'b0, 16'h0000, 1'b0, 1};
      tbl[8]  = '{F_SLL,  0, 5, 0, 1'b1, 7,   1'b0, 16'h0080, 1'b0, 1};
      tbl[9]  = '{F_SRL,  0, 7, 0, 1'b1, 3,   1'b0, 16'h000B, 1'b0, 1};
      tbl[10] = '{F_LTU,  0, 0, 0, 1'b1, 3,   1'b0, 16'h0001, 1'b0, 1};
      tbl[11] = '{F_GEU,  0, 0, 0, 1'b1, 3,   1'b0, 16'h0000, 1'b0, 1};
      tbl[12] = '{F_EQ,   0, 5, 1, 1'b0, 0,   1'b0, 16'h0001, 1'b0, 1};
      tbl[13] = '{F_XOR,  0, 2, 4, 1'b0, 0,   1'b0, 16'h0000, 1'b0, 1};
      tbl[14] = '{F_DIV,  5, 7, 0, 1'b1, 7,   1'b0, 16'h000C, 1'b0, 9};
      tbl[15] = '{F_MOD,  5, 7, 0, 1'b1, 7,   1'b0, 16'h0004, 1'b0, 9};
      tbl[16] = '{F_NOT,  0, 6, 0, 1'b1, 0,   1'b0, 16'h00FF, 1'b0, 1};

      rst_n = 1'b0; instr_valid = 1'b0; func = 4'd0; rd = '0; rs1 = '0; rs2 = '0;
      imm_sel = 1'b0; imm = '0; wr_en = 1'b0; dbg_addr = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(instr_ready), 64'd1);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_data",  64'(res_data), 64'd0);
      chk("rst_zero",  64'(flag_zero), 64'd1);
      chk("rst_carry", 64'(flag_carry), 64'd0);
      model_reset();
      sweep("rst");

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         a = mreg[tbl[i].rs1];
         b = tbl[i].isel ? tbl[i].imm : mreg[tbl[i].rs2];
         exec_check($sformatf("tbl%0d", i), tbl[i].f, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                    tbl[i].isel, tbl[i].imm, tbl[i].we, tbl[i].exp_data, tbl[i].exp_c,
                    tbl[i].exp_lat);
         model_calc(tbl[i].f, a, b, res, c, lat);
         model_commit(tbl[i].f, tbl[i].rd, res, tbl[i].we);
      end
      sweep("tbl");
      dbg_addr = AW'(7); #1 chk("mul_lo_r7", 64'(dbg_data), 64'h58);
      dbg_addr = AW'(0); #1 chk("mul_hi_r0", 64'(dbg_data), 64'h02);

      // ADD held pending while a MUL iterates.
      @(negedge clk);
      func = F_MUL; rd = AW'(0); rs1 = AW'(0); imm_sel = 1'b1; imm = DW'(100); wr_en = 1'b0;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 func = F_ADD; rd = AW'(1); rs1 = AW'(1); imm = DW'(10); wr_en = 1'b1;
      pulses = 0; first_k = 0; second_k = 0; first_d = 0; second_d = 0; ready_bad = 0;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (!instr_valid && j > 1) begin end
         if (res_valid) begin
            pulses++;
            if (pulses == 1) begin first_k = j; first_d = 64'(res_data); end
            else begin second_k = j; second_d = 64'(res_data); end
         end
         if (j <= 8 && instr_ready) ready_bad++;
         if (instr_valid && instr_ready) begin
            @(posedge clk);
            #1 instr_valid = 1'b0;
         end
      end
      chk("hold_pulses", 64'(pulses), 64'd2);
      chk("hold_mul_k", 64'(first_k), 64'd9);
      chk("hold_mul_d", first_d, 64'h00C8);
      chk("hold_add_k", 64'(second_k), 64'd10);
      chk("hold_add_d", second_d, 64'd15);
      chk("hold_ready_low", 64'(ready_bad), 64'd0);
      mreg[1] = 15;
      sweep("hold");

      // Reset in the middle of a MUL aborts it.
      @(negedge clk);
      func = F_MUL; rd = AW'(3); rs1 = AW'(7); imm_sel = 1'b1; imm = DW'(5); wr_en = 1'b1;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      pulses = 0;
      for (k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (res_valid) pulses++;
      end
      rst_n = 1'b0;
      #1 chk("abort_ready_in_rst", 64'(instr_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         if (res_valid) pulses++;
      end
      chk("abort_no_pulse", 64'(pulses), 64'd0);
      chk("abort_ready", 64'(instr_ready), 64'd1);
      chk("abort_data", 64'(res_data), 64'd0);
      chk("abort_zero", 64'(flag_zero), 64'd1);
      model_reset();
      sweep("abort");

      // Randomised instructions against the model.
      for (int n = 0; n < 200; n++) begin
         logic [3:0] f;
         int rdi, r1, r2;
         bit isel, we;
         longint unsigned immv;
         f = 4'($urandom_range(15, 0));
         rdi = $urandom_range(NR - 1, 0);
         r1 = $urandom_range(NR - 1, 0);
         r2 = $urandom_range(NR - 1, 0);
         isel = 1'($urandom_range(1, 0));
         we = ($urandom_range(3, 0) != 0);
         case ($urandom_range(3, 0))
            0:       immv = 64'($urandom_range(DW + 2, 0));
            1:       immv = 0;
            default: immv = 64'($urandom_range(255, 0));
         endcase
         a = mreg[r1];
         b = isel ? immv : mreg[r2];
         model_calc(f, a, b, res, c, lat);
         exec_check($sformatf("rnd%0d_f%0d", n, f), f, rdi, r1, r2, isel, immv, we, res, c, lat);
         model_commit(f, rdi, res, we);
         if (n % 40 == 39) sweep($sformatf("rnd%0d", n));
      end
      sweep("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
